// File: rtl/rib_pkg.sv
// rib_pkg: RIB bus field widths, GPIO register map and FSM states.
// Shared by rib_gpio and its sub-blocks.
package rib_pkg;

  localparam int RIB_ADDR_W = 32;
  localparam int RIB_DATA_W = 32;
  localparam int RIB_MASK_W = 4;

  localparam logic [4:0] GPIO_MODE_OFS    = 5'h00;
  localparam logic [4:0] GPIO_OUT_OFS     = 5'h04;
  localparam logic [4:0] GPIO_IN_OFS      = 5'h08;
  localparam logic [4:0] GPIO_EDGE_EN_OFS = 5'h0C;
  localparam logic [4:0] GPIO_EDGE_ST_OFS = 5'h10;

  typedef enum logic {
    RIB_IDLE = 1'b0,
    RIB_RESP = 1'b1
  } rib_state_t;

  function automatic logic [RIB_DATA_W-1:0] rib_byte_mask(
    input logic [RIB_MASK_W-1:0] m
  );
    logic [RIB_DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < RIB_MASK_W; i++) begin
      r[i*8 +: 8] = {8{m[i]}};
    end
    return r;
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: two-flop pad synchronizer plus rising-edge detect.
// rise is high for one cycle after sync goes 0->1.
module gpio_sync_edge #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] pad,
  output logic [W-1:0] sync,
  output logic [W-1:0] rise
);

  logic [W-1:0] s1;
  logic [W-1:0] s2;
  logic [W-1:0] prev;

  // Synchronizer chain and previous-value flop for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= pad;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign sync = s2;
  assign rise = s2 & ~prev;

endmodule

// File: rtl/rib_gpio.sv
// rib_gpio: RIB slave GPIO controller with edge-status interrupt.
// One outstanding transfer; response registered one cycle after grant.
module rib_gpio
  import rib_pkg::*;
#(
  parameter int GPIO_W = 24,
  parameter int ADDR_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [RIB_ADDR_W-1:0] i_ribs_addr,
  input  logic                  i_ribs_wrcs,
  input  logic [RIB_MASK_W-1:0] i_ribs_mask,
  input  logic [RIB_DATA_W-1:0] i_ribs_wdata,
  output logic [RIB_DATA_W-1:0] o_ribs_rdata,
  input  logic                  i_ribs_req,
  output logic                  o_ribs_gnt,
  output logic                  o_ribs_rsp,
  input  logic                  i_ribs_rdy,
  output logic [GPIO_W-1:0]     o_gpio_mode,
  output logic [GPIO_W-1:0]     o_gpio_out,
  input  logic [GPIO_W-1:0]     i_gpio_in,
  output logic                  o_irq
);

  rib_state_t state;

  logic [GPIO_W-1:0] mode_r;
  logic [GPIO_W-1:0] out_r;
  logic [GPIO_W-1:0] en_r;
  logic [GPIO_W-1:0] st_r;
  logic [GPIO_W-1:0] st_nxt;
  logic [GPIO_W-1:0] in_sync;
  logic [GPIO_W-1:0] rise;

  logic              gnt;
  logic [ADDR_W-1:0] ofs;
  logic              sel_mode;
  logic              sel_out;
  logic              sel_in;
  logic              sel_en;
  logic              sel_st;
  logic              wr;

  logic [RIB_DATA_W-1:0] wm_full;
  logic [GPIO_W-1:0]     wm;
  logic [GPIO_W-1:0]     wd;
  logic [GPIO_W-1:0]     clr;
  logic [GPIO_W-1:0]     rd_val;
  logic [RIB_DATA_W-1:0] rd_word;
  logic                  unused_bits;

  gpio_sync_edge #(
    .W(GPIO_W)
  ) u_sync (
    .clk  (i_clk),
    .rst  (i_reset),
    .pad  (i_gpio_in),
    .sync (in_sync),
    .rise (rise)
  );

  assign ofs = {i_ribs_addr[ADDR_W-1:2], 2'b00};

  assign sel_mode = ofs == ADDR_W'(GPIO_MODE_OFS);
  assign sel_out  = ofs == ADDR_W'(GPIO_OUT_OFS);
  assign sel_in   = ofs == ADDR_W'(GPIO_IN_OFS);
  assign sel_en   = ofs == ADDR_W'(GPIO_EDGE_EN_OFS);
  assign sel_st   = ofs == ADDR_W'(GPIO_EDGE_ST_OFS);

  assign wm_full = rib_byte_mask(i_ribs_mask);
  assign wm      = wm_full[GPIO_W-1:0];
  assign wd      = i_ribs_wdata[GPIO_W-1:0];
  assign wr      = gnt & i_ribs_wrcs;
  assign clr     = (wr & sel_st) ? (wd & wm) : '0;
  assign st_nxt  = (st_r & ~clr) | (rise & en_r);

  assign unused_bits = ^{i_ribs_addr[RIB_ADDR_W-1:ADDR_W],
                         i_ribs_addr[1:0], i_ribs_wdata, wm_full};

  assign o_ribs_gnt  = gnt;
  assign o_gpio_mode = mode_r;
  assign o_gpio_out  = out_r;

  // Grant: free when idle, or when the current response is consumed
  always_comb begin
    gnt = 1'b0;
    unique case (state)
      RIB_IDLE: gnt = i_ribs_req;
      RIB_RESP: gnt = i_ribs_req & i_ribs_rdy;
      default:  gnt = 1'b0;
    endcase
    if (i_reset) gnt = 1'b0;
  end

  // Read mux, sampled before any same-cycle write lands
  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      sel_mode: rd_val = mode_r;
      sel_out:  rd_val = out_r;
      sel_in:   rd_val = in_sync;
      sel_en:   rd_val = en_r;
      sel_st:   rd_val = st_r;
      default:  rd_val = '0;
    endcase
    rd_word = '0;
    rd_word[GPIO_W-1:0] = rd_val;
  end

  // Register file: byte-masked writes, W1C edge status, irq
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      mode_r <= '0;
      out_r  <= '0;
      en_r   <= '0;
      st_r   <= '0;
      o_irq  <= 1'b0;
    end else begin
      if (wr & sel_mode) mode_r <= (mode_r & ~wm) | (wd & wm);
      if (wr & sel_out)  out_r  <= (out_r & ~wm) | (wd & wm);
      if (wr & sel_en)   en_r   <= (en_r & ~wm) | (wd & wm);
      st_r  <= st_nxt;
      o_irq <= |st_nxt;
    end
  end

  // Handshake FSM with registered response and read data
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= RIB_IDLE;
      o_ribs_rsp   <= 1'b0;
      o_ribs_rdata <= '0;
    end else begin
      unique case (state)
        RIB_IDLE: begin
          if (gnt) begin
            state        <= RIB_RESP;
            o_ribs_rsp   <= 1'b1;
            o_ribs_rdata <= i_ribs_wrcs ? '0 : rd_word;
          end
        end
        RIB_RESP: begin
          if (gnt) begin
            o_ribs_rsp   <= 1'b1;
            o_ribs_rdata <= i_ribs_wrcs ? '0 : rd_word;
          end else if (i_ribs_rdy) begin
            state        <= RIB_IDLE;
            o_ribs_rsp   <= 1'b0;
            o_ribs_rdata <= '0;
          end
        end
        default: state <= RIB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rib_gpio.sv
// tb_rib_gpio: scoreboard bench for the rib_gpio controller.
// Expected rdata is queued at grant and popped at response.
module tb_rib_gpio;

  localparam int GPIO_W = 24;

  logic              clk;
  logic              rst;
  logic [31:0]       addr;
  logic              wrcs;
  logic [3:0]        mask;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              req;
  logic              gnt;
  logic              rsp;
  logic              rdy;
  logic [GPIO_W-1:0] mode;
  logic [GPIO_W-1:0] out;
  logic [GPIO_W-1:0] gpio_in;
  logic              irq;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0]       sb[$];
  logic [31:0]       e;
  logic              s_rsp;
  logic [31:0]       s_rdata;
  logic [GPIO_W-1:0] s_mode;
  logic [GPIO_W-1:0] s_out;
  logic              s_irq;

  rib_gpio #(
    .GPIO_W(GPIO_W),
    .ADDR_W(5)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_ribs_addr  (addr),
    .i_ribs_wrcs  (wrcs),
    .i_ribs_mask  (mask),
    .i_ribs_wdata (wdata),
    .o_ribs_rdata (rdata),
    .i_ribs_req   (req),
    .o_ribs_gnt   (gnt),
    .o_ribs_rsp   (rsp),
    .i_ribs_rdy   (rdy),
    .o_gpio_mode  (mode),
    .o_gpio_out   (out),
    .i_gpio_in    (gpio_in),
    .o_irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: sim time limit reached, need $finish");
    $fatal(1, "watchdog");
  end

  task automatic bus_xfer(input logic wr, input logic [31:0] a,
                          input logic [3:0] m, input logic [31:0] wd,
                          input logic [31:0] exp);
    int n;
    @(posedge clk); #1;
    req = 1'b1; wrcs = wr; addr = a; mask = m; wdata = wd; rdy = 1'b1;
    n = 0;
    @(negedge clk);
    while (gnt !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    sb.push_back(exp);
    if (gnt !== 1'b1) begin
      n_cmp++; n_fail++;
      $display("FAIL grant_timeout addr=%h got gnt=%b need 1", a, gnt);
      req = 1'b0;
      s_rsp = 1'b0; s_rdata = 32'hDEAD_BEEF;
      s_mode = mode; s_out = out; s_irq = irq;
      return;
    end
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    s_rsp = rsp; s_rdata = rdata;
    s_mode = mode; s_out = out; s_irq = irq;
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 1'b0; wrcs = 1'b0; addr = '0;
    mask = '0; wdata = '0; rdy = 1'b0; gpio_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (rsp !== 1'b0) begin n_fail++; $display("FAIL rst_rsp got %b need 0", rsp); end
    n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h need 0", rdata); end
    n_cmp++; if (gnt !== 1'b0) begin n_fail++; $display("FAIL rst_gnt got %b need 0", gnt); end
    n_cmp++; if (mode !== 24'h0) begin n_fail++; $display("FAIL rst_mode got %h need 0", mode); end
    n_cmp++; if (out !== 24'h0) begin n_fail++; $display("FAIL rst_out got %h need 0", out); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq got %b need 0", irq); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_mode_write;
    bus_xfer(1'b1, 32'h00, 4'b0001, 32'h0000000F, 32'h0);
    e = sb.pop_front();
    n_cmp++; if (s_rsp !== 1'b1) begin n_fail++; $display("FAIL mode_wr_rsp got %b need 1", s_rsp); end
    n_cmp++; if (s_rdata !== e) begin n_fail++; $display("FAIL mode_wr_rdata got %h need %h", s_rdata, e); end
    n_cmp++; if (s_mode !== 24'h00000F) begin n_fail++; $display("FAIL mode_pins got %h need 00000f", s_mode); end
    bus_xfer(1'b0, 32'h00, 4'b1111, 32'h0, 32'h0000000F);
    e = sb.pop_front();
    n_cmp++; if (s_rsp !== 1'b1) begin n_fail++; $display("FAIL mode_rd_rsp got %b need 1", s_rsp); end
    n_cmp++; if (s_rdata !== e) begin n_fail++; $display("FAIL mode_rd got %h need %h", s_rdata, e); end
  endtask

  task automatic test_mask;
    bus_xfer(1'b1, 32'h04, 4'b0010, 32'h00A5A5A5, 32'h0);
    e = sb.pop_front();
    n_cmp++; if (s_out !== 24'h00A500) begin n_fail++; $display("FAIL mask_out got %h need 00a500", s_out); end
    bus_xfer(1'b0, 32'h04, 4'b0000, 32'h0, 32'h0000A500);
    e = sb.pop_front();
    n_cmp++; if (s_rdata !== e) begin n_fail++; $display("FAIL mask_rd got %h need %h", s_rdata, e); end
    bus_xfer(1'b1, 32'h04, 4'b1111, 32'hFFFFFFFF, 32'h0);
    e = sb.pop_front();
    bus_xfer(1'b0, 32'h04, 4'b0000, 32'h0, 32'h00FFFFFF);
    e = sb.pop_front();
    n_cmp++; if (s_rdata !== e) begin n_fail++; $display("FAIL mask_upper got %h need %h", s_rdata, e); end
    bus_xfer(1'b1, 32'h04, 4'b0101, 32'h0, 32'h0);
    e = sb.pop_front();
    n_cmp++; if (s_out !== 24'h00FF00) begin n_fail++; $display("FAIL mask_clr_bytes got %h need 00ff00", s_out); end
  endtask

  task automatic test_edge_irq;
    bus_xfer(1'b1, 32'h0C, 4'b0001, 32'h00000004, 32'h0);
    e = sb.pop_front();
    @(posedge clk); #1;
    gpio_in[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_cyc1 got %b need 0", irq); end
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_cyc2 got %b need 0", irq); end
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_cyc3 got %b need 1", irq); end
    bus_xfer(1'b0, 32'h10, 4'b0000, 32'h0, 32'h00000004);
    e = sb.pop_front();
    n_cmp++; if (s_rdata !== e) begin n_fail++; $display("FAIL edge_st_rd got %h need %h", s_rdata, e); end
    bus_xfer(1'b0, 32'h08, 4'b0000, 32'h0, 32'h00000004);
    e = sb.pop_front();
    n_cmp++; if (s_rdata !== e) begin n_fail++; $display("FAIL in_rd got %h need %h", s_rdata, e); end
    bus_xfer(1'b1, 32'h10, 4'b0001, 32'h00000004, 32'h0);
    e = sb.pop_front();
    n_cmp++; if (s_irq !== 1'b0) begin n_fail++; $display("FAIL w1c_irq got %b need 0", s_irq); end
    bus_xfer(1'b0, 32'h10, 4'b0000, 32'h0, 32'h0);
    e = sb.pop_front();
    n_cmp++; if (s_rdata !== e) begin n_fail++; $display("FAIL w1c_st got %h need %h", s_rdata, e); end
    @(posedge clk); #1;
    gpio_in[3] = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_disabled_pin got %b need 0", irq); end
  endtask

  task automatic test_set_wins;
    @(posedge clk); #1;
    gpio_in[2] = 1'b0;
    repeat (4) @(posedge clk);
    #1 gpio_in[2] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL setwin_pre_irq got %b need 1", irq); end
    @(posedge clk); #1;
    gpio_in[2] = 1'b0;
    repeat (4) @(posedge clk);
    #1 gpio_in[2] = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    req = 1'b1; wrcs = 1'b1; addr = 32'h10; mask = 4'b0001;
    wdata = 32'h4; rdy = 1'b1;
    @(negedge clk);
    n_cmp++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL setwin_gnt got %b need 1", gnt); end
    sb.push_back(32'h0);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++; if (rsp !== 1'b1) begin n_fail++; $display("FAIL setwin_rsp got %b need 1", rsp); end
    n_cmp++; if (rdata !== e) begin n_fail++; $display("FAIL setwin_rdata got %h need %h", rdata, e); end
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL setwin_irq got %b need 1", irq); end
    bus_xfer(1'b0, 32'h10, 4'b0000, 32'h0, 32'h00000004);
    e = sb.pop_front();
    n_cmp++; if (s_rdata !== e) begin n_fail++; $display("FAIL setwin_st got %h need %h", s_rdata, e); end
    bus_xfer(1'b1, 32'h10, 4'b0001, 32'h00000004, 32'h0);
    e = sb.pop_front();
    n_cmp++; if (s_irq !== 1'b0) begin n_fail++; $display("FAIL setwin_clear got %b need 0", s_irq); end
  endtask

  task automatic test_backpressure;
    @(posedge clk); #1;
    req = 1'b1; wrcs = 1'b0; addr = 32'h08; rdy = 1'b0;
    @(negedge clk);
    n_cmp++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL bp_first_gnt got %b need 1", gnt); end
    sb.push_back({8'h0, gpio_in});
    @(posedge clk); #1;
    addr = 32'h00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++; if (rsp !== 1'b1) begin n_fail++; $display("FAIL bp_rsp%0d got %b need 1", k, rsp); end
      n_cmp++; if (rdata !== sb[0]) begin n_fail++; $display("FAIL bp_rdata%0d got %h need %h", k, rdata, sb[0]); end
      n_cmp++; if (gnt !== 1'b0) begin n_fail++; $display("FAIL bp_gnt%0d got %b need 0", k, gnt); end
      @(posedge clk);
    end
    #1 rdy = 1'b1;
    @(negedge clk);
    n_cmp++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL bp_release_gnt got %b need 1", gnt); end
    e = sb.pop_front();
    n_cmp++; if (rdata !== e) begin n_fail++; $display("FAIL bp_first_rd got %h need %h", rdata, e); end
    sb.push_back(32'h0000000F);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++; if (rsp !== 1'b1) begin n_fail++; $display("FAIL bp_next_rsp got %b need 1", rsp); end
    n_cmp++; if (rdata !== e) begin n_fail++; $display("FAIL bp_next_rd got %h need %h", rdata, e); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a_tab[4];
    logic [31:0] x_tab[4];
    a_tab = '{32'h00, 32'h04, 32'h0C, 32'h08};
    x_tab = '{32'h0000000F, 32'h0000FF00, 32'h00000004, 32'h0000000C};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      req = 1'b1; wrcs = 1'b0; rdy = 1'b1; addr = a_tab[i];
      @(negedge clk);
      n_cmp++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt%0d got %b need 1", i, gnt); end
      if (i > 0) begin
        e = sb.pop_front();
        n_cmp++; if (rdata !== e || rsp !== 1'b1) begin n_fail++; $display("FAIL b2b_rd%0d got %h/%b need %h/1", i - 1, rdata, rsp, e); end
      end
      sb.push_back(x_tab[i]);
    end
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++; if (rdata !== e || rsp !== 1'b1) begin n_fail++; $display("FAIL b2b_rd3 got %h/%b need %h/1", rdata, rsp, e); end
  endtask

  task automatic test_unmapped;
    bus_xfer(1'b0, 32'h18, 4'b0000, 32'h0, 32'h0);
    e = sb.pop_front();
    n_cmp++; if (s_rsp !== 1'b1) begin n_fail++; $display("FAIL unmap_rsp got %b need 1", s_rsp); end
    n_cmp++; if (s_rdata !== e) begin n_fail++; $display("FAIL unmap_rd got %h need %h", s_rdata, e); end
    bus_xfer(1'b1, 32'h14, 4'b1111, 32'hFFFFFFFF, 32'h0);
    e = sb.pop_front();
    n_cmp++; if (s_rsp !== 1'b1) begin n_fail++; $display("FAIL unmap_wr_rsp got %b need 1", s_rsp); end
    bus_xfer(1'b0, 32'h14, 4'b0000, 32'h0, 32'h0);
    e = sb.pop_front();
    n_cmp++; if (s_rdata !== e) begin n_fail++; $display("FAIL unmap_wr_rd got %h need %h", s_rdata, e); end
    bus_xfer(1'b1, 32'h08, 4'b1111, 32'hFFFFFFFF, 32'h0);
    e = sb.pop_front();
    bus_xfer(1'b0, 32'h08, 4'b0000, 32'h0, 32'h0000000C);
    e = sb.pop_front();
    n_cmp++; if (s_rdata !== e) begin n_fail++; $display("FAIL in_ro got %h need %h", s_rdata, e); end
    bus_xfer(1'b0, 32'hFFFF_FF00, 4'b0000, 32'h0, 32'h0000000F);
    e = sb.pop_front();
    n_cmp++; if (s_rdata !== e) begin n_fail++; $display("FAIL upper_addr got %h need %h", s_rdata, e); end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    req = 1'b1; wrcs = 1'b0; addr = 32'h00; rdy = 1'b0;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    n_cmp++; if (rsp !== 1'b1) begin n_fail++; $display("FAIL rm_pre_rsp got %b need 1", rsp); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (rsp !== 1'b0) begin n_fail++; $display("FAIL rm_async_rsp got %b need 0", rsp); end
    n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rm_async_rdata got %h need 0", rdata); end
    @(posedge clk); #1;
    rst = 1'b0; rdy = 1'b1;
    @(negedge clk);
    n_cmp++; if (rsp !== 1'b0) begin n_fail++; $display("FAIL rm_post_rsp got %b need 0", rsp); end
    bus_xfer(1'b0, 32'h00, 4'b0000, 32'h0, 32'h0);
    e = sb.pop_front();
    n_cmp++; if (s_rsp !== 1'b1) begin n_fail++; $display("FAIL rm_idle_rsp got %b need 1", s_rsp); end
    n_cmp++; if (s_rdata !== e) begin n_fail++; $display("FAIL rm_mode_rd got %h need %h", s_rdata, e); end
    n_cmp++; if (s_mode !== 24'h0) begin n_fail++; $display("FAIL rm_mode_pins got %h need 0", s_mode); end
  endtask

  initial begin
    test_reset();
    test_mode_write();
    test_mask();
    test_edge_irq();
    test_set_wins();
    test_backpressure();
    test_back_to_back();
    test_unmapped();
    test_reset_mid();
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover got %0d need 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
